multicycle_control: RTL and testbench

Multi-cycle RV32I control unit. It replaces the single-cycle opcode decoder with a registered state machine that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one memory port. It adds a memory ready/request handshake, full branch-condition support, JALR, LUI/AUIPC, an illegal-instruction trap and a retired-instruction counter. It sits between the instruction register and the datapath muxes/enables of the multi-cycle core.

---
 rtl/multicycle_control.sv | 263 ++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back
// over one shared ALU and memory port, with illegal-instruction trap and retire counter.
module multicycle_control #(
  parameter int MEM_WAIT        = 1,
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic [3:0]       alu_control,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  // Memory handshake: mem_req is held high until the cycle mem_ready is seen;
  // strobes that depend on completion fire only in that ready cycle.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_JALR_PC  = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rdy;
  logic             req_c, wr_c, adr_c, irw_c, pcw_c, rw_c, ret_c, ill_c;
  logic             br_taken, br_bad;

  assign rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = ~ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE:         imm_src = 3'b001;
      OP_BRANCH:        imm_src = 3'b010;
      OP_JAL:           imm_src = 3'b011;
      OP_LUI, OP_AUIPC: imm_src = 3'b100;
      default:          imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_c       = 1'b0;
    wr_c        = 1'b0;
    adr_c       = 1'b0;
    irw_c       = 1'b0;
    pcw_c       = 1'b0;
    rw_c        = 1'b0;
    ret_c       = 1'b0;
    ill_c       = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        req_c      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw_c      = rdy;
        pcw_c      = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
            ill_c   = 1'b1;
            state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        req_c = 1'b1;
        adr_c = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        rw_c       = 1'b1;
        ret_c      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c = 1'b1;
        adr_c = 1'b1;
        wr_c  = 1'b1;
        ret_c = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec(funct3, funct7_5, 1'b1);
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec(funct3, funct7_5, 1'b0);
        state_d     = S_ALUWB;
      end
      S_UPPER: begin
        alu_src_a = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcw_c     = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        if (br_bad) begin
          ill_c   = 1'b1;
          state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        end else begin
          pcw_c   = br_taken;
          ret_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_JALR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        rw_c       = 1'b1;
        state_d    = S_JALR_PC;
      end
      S_JALR_PC: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pcw_c      = 1'b1;
        ret_c      = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        ill_c = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign instret_d = instret_q + CNT_W'(ret_c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are suppressed while reset is held so an abandoned instruction has no side effects.
  assign mem_req   = req_c & ~rst;
  assign mem_write = wr_c  & ~rst;
  assign ir_write  = irw_c & ~rst;
  assign pc_write  = pcw_c & ~rst;
  assign reg_write = rw_c  & ~rst;
  assign retire    = ret_c & ~rst;
  assign illegal   = ill_c & ~rst;
  assign adr_src   = adr_c;
  assign state     = state_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words are queued
// by the driver and compared by an independent negedge monitor.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal, retire;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic [3:0]  alu_control, state;
  logic [31:0] instret;

  logic        mem_req2, mem_write2, adr_src2, ir_write2, pc_write2, reg_write2, illegal2, retire2;
  logic [1:0]  alu_src_a2, alu_src_b2, result_src2;
  logic [2:0]  imm_src2;
  logic [3:0]  alu_control2, state2, instret2;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control), .state(state),
    .illegal(illegal), .retire(retire), .instret(instret)
  );

  multicycle_control #(.MEM_WAIT(1), .TRAP_ON_ILLEGAL(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_write(mem_write2), .adr_src(adr_src2), .ir_write(ir_write2),
    .pc_write(pc_write2), .reg_write(reg_write2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2),
    .result_src(result_src2), .imm_src(imm_src2), .alu_control(alu_control2), .state(state2),
    .illegal(illegal2), .retire(retire2), .instret(instret2)
  );

  always #5 clk = ~clk;

  // Strobe byte order: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal}
  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_FR    = 8'b1001_1000;
  localparam logic [7:0] S_FW    = 8'b1000_0000;
  localparam logic [7:0] S_WB    = 8'b0000_0110;
  localparam logic [7:0] S_MRD   = 8'b1010_0000;
  localparam logic [7:0] S_MWR   = 8'b1110_0000;
  localparam logic [7:0] S_MWR_R = 8'b1110_0010;
  localparam logic [7:0] S_LINK  = 8'b0000_0100;
  localparam logic [7:0] S_PCRET = 8'b0000_1010;
  localparam logic [7:0] S_PC    = 8'b0000_1000;
  localparam logic [7:0] S_ILL   = 8'b0000_0001;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [9:0]  exp2_q[$];
  logic [32:0] e1, got1;
  logic [9:0]  e2, got2;
  bit          mon_en = 1'b0, mon2_en = 1'b0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [3:0]  exp2_cnt = 4'd0;

  assign got1 = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal,
                 alu_src_a, alu_src_b, result_src, alu_control, imm_src, instret[7:0]};
  assign got2 = {state2, illegal2, retire2, instret2};

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL trace t=%0t: DUT output with no expected entry, got %h", $time, got1);
      end else begin
        e1 = exp_q.pop_front();
        if (got1 !== e1) begin
          errors++;
          $display("FAIL trace t=%0t state got %0d want %0d | word got %h want %h",
                   $time, got1[32:29], e1[32:29], got1, e1);
        end
      end
    end
    if (mon2_en) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL trace2 t=%0t: no expected entry, got %h", $time, got2);
      end else begin
        e2 = exp2_q.pop_front();
        if (got2 !== e2) begin
          errors++;
          $display("FAIL trace2 t=%0t {state,ill,ret,instret} got %h want %h", $time, got2, e2);
        end
      end
    end
  end

  // rdy: 0/1 drive that value, 2 drive a random value (memory-ready ignored in that state)
  task automatic step(input int rdy);
    mem_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy != 0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [3:0] st, input logic [7:0] s, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] rs, input logic [3:0] alu,
                     input logic [2:0] imm, input int rdy);
    exp_q.push_back({st, s, a, b, rs, alu, imm, exp_cnt});
    if (s[1]) exp_cnt++;
    step(rdy);
  endtask

  task automatic push2(input logic [3:0] st, input logic ill, input logic ret);
    exp2_q.push_back({st, ill, ret, exp2_cnt});
    if (ret) exp2_cnt++;
  endtask

  task automatic set_ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7_5 = f7;
  endtask

  task automatic fetch(input logic [2:0] imm, input int nw);
    repeat (nw) cyc(4'd0, S_FW, 2'b00, 2'b10, 2'b10, 4'd0, imm, 0);
    cyc(4'd0, S_FR, 2'b00, 2'b10, 2'b10, 4'd0, imm, 1);
  endtask

  task automatic decode(input logic [2:0] imm);
    cyc(4'd1, S_NONE, 2'b01, 2'b01, 2'b00, 4'd0, imm, 2);
  endtask

  task automatic aluwb(input logic [2:0] imm);
    cyc(4'd8, S_WB, 2'b00, 2'b00, 2'b00, 4'd0, imm, 2);
  endtask

  task automatic do_r(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
    set_ins(7'b0110011, f3, f7);
    fetch(3'd0, 0); decode(3'd0);
    cyc(4'd6, S_NONE, 2'b10, 2'b00, 2'b00, alu, 3'd0, 2);
    aluwb(3'd0);
  endtask

  task automatic do_i(input logic [2:0] f3, input logic f7, input logic [3:0] alu);
    set_ins(7'b0010011, f3, f7);
    fetch(3'd0, 0); decode(3'd0);
    cyc(4'd7, S_NONE, 2'b10, 2'b01, 2'b00, alu, 3'd0, 2);
    aluwb(3'd0);
  endtask

  task automatic do_load(input int nf, input int nm);
    set_ins(7'b0000011, 3'b010, 1'b0);
    fetch(3'd0, nf); decode(3'd0);
    cyc(4'd2, S_NONE, 2'b10, 2'b01, 2'b00, 4'd0, 3'd0, 2);
    repeat (nm) cyc(4'd3, S_MRD, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0);
    cyc(4'd3, S_MRD, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 1);
    cyc(4'd4, S_WB, 2'b00, 2'b00, 2'b01, 4'd0, 3'd0, 2);
  endtask

  task automatic do_store(input int nm);
    set_ins(7'b0100011, 3'b010, 1'b0);
    fetch(3'd1, 0); decode(3'd1);
    cyc(4'd2, S_NONE, 2'b10, 2'b01, 2'b00, 4'd0, 3'd1, 2);
    repeat (nm) cyc(4'd5, S_MWR, 2'b00, 2'b00, 2'b00, 4'd0, 3'd1, 0);
    cyc(4'd5, S_MWR_R, 2'b00, 2'b00, 2'b00, 4'd0, 3'd1, 1);
  endtask

  task automatic do_branch(input logic [6:0] v);
    set_ins(7'b1100011, v[6:4], 1'b0);
    zero = v[3]; lt = v[2]; ltu = v[1];
    fetch(3'd2, 0); decode(3'd2);
    cyc(4'd10, {4'b0000, v[0], 3'b010}, 2'b10, 2'b00, 2'b00, 4'd1, 3'd2, 2);
  endtask

  task automatic do_upper(input logic [6:0] op, input logic [1:0] a);
    set_ins(op, 3'b000, 1'b0);
    fetch(3'd4, 0); decode(3'd4);
    cyc(4'd12, S_NONE, a, 2'b01, 2'b00, 4'd0, 3'd4, 2);
    aluwb(3'd4);
  endtask

  task automatic d2_addi();
    set_ins(7'b0010011, 3'b000, 1'b0);
    push2(4'd0, 1'b0, 1'b0); step(1);
    push2(4'd1, 1'b0, 1'b0); step(2);
    push2(4'd7, 1'b0, 1'b0); step(2);
    push2(4'd8, 1'b0, 1'b1); step(2);
  endtask

  // {funct3, zero, lt, ltu, taken}; unused flags are set opposite to catch wrong selects
  logic [6:0] br_tab [12] = '{
    {3'b000, 1'b1, 1'b0, 1'b1, 1'b1}, {3'b000, 1'b0, 1'b1, 1'b0, 1'b0},
    {3'b001, 1'b0, 1'b1, 1'b1, 1'b1}, {3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
    {3'b100, 1'b1, 1'b1, 1'b0, 1'b1}, {3'b100, 1'b0, 1'b0, 1'b1, 1'b0},
    {3'b101, 1'b1, 1'b0, 1'b1, 1'b1}, {3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
    {3'b110, 1'b0, 1'b0, 1'b1, 1'b1}, {3'b110, 1'b1, 1'b1, 1'b0, 1'b0},
    {3'b111, 1'b1, 1'b1, 1'b0, 1'b1}, {3'b111, 1'b0, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(4'd0, S_NONE, 2'b00, 2'b10, 2'b10, 4'd0, 3'd0, 1);
    exp_cnt = 8'd0;
    rst = 1'b0;

    do_r(3'b000, 1'b0, 4'd0);
    do_load(2, 2);
    do_store(1);
    do_r(3'b000, 1'b1, 4'd1);
    do_r(3'b101, 1'b1, 4'd9);
    do_r(3'b111, 1'b0, 4'd2);
    do_r(3'b010, 1'b0, 4'd5);
    do_i(3'b101, 1'b1, 4'd9);
    do_i(3'b000, 1'b1, 4'd0);
    do_i(3'b011, 1'b0, 4'd6);
    do_i(3'b001, 1'b0, 4'd7);
    for (int i = 0; i < 12; i++) do_branch(br_tab[i]);
    do_upper(7'b0110111, 2'b11);
    do_upper(7'b0010111, 2'b01);

    set_ins(7'b1101111, 3'b000, 1'b0);
    fetch(3'd3, 0); decode(3'd3);
    cyc(4'd9, S_PC, 2'b01, 2'b10, 2'b00, 4'd0, 3'd3, 2);
    aluwb(3'd3);

    set_ins(7'b1100111, 3'b000, 1'b0);
    fetch(3'd0, 0); decode(3'd0);
    cyc(4'd11, S_LINK, 2'b01, 2'b10, 2'b10, 4'd0, 3'd0, 2);
    cyc(4'd13, S_PCRET, 2'b10, 2'b01, 2'b10, 4'd0, 3'd0, 2);

    // reset lands in the ready cycle of a store: no write, no retire
    set_ins(7'b0100011, 3'b010, 1'b0);
    fetch(3'd1, 0); decode(3'd1);
    cyc(4'd2, S_NONE, 2'b10, 2'b01, 2'b00, 4'd0, 3'd1, 2);
    rst = 1'b1;
    cyc(4'd5, 8'b0010_0000, 2'b00, 2'b00, 2'b00, 4'd0, 3'd1, 1);
    exp_cnt = 8'd0;
    rst = 1'b0;
    do_r(3'b000, 1'b0, 4'd0);

    // illegal branch funct3 traps and holds until reset
    set_ins(7'b1100011, 3'b010, 1'b0);
    fetch(3'd2, 0); decode(3'd2);
    cyc(4'd10, S_ILL, 2'b10, 2'b00, 2'b00, 4'd1, 3'd2, 2);
    cyc(4'd15, S_ILL, 2'b00, 2'b00, 2'b00, 4'd0, 3'd2, 1);
    cyc(4'd15, S_ILL, 2'b00, 2'b00, 2'b00, 4'd0, 3'd2, 1);
    rst = 1'b1;
    cyc(4'd15, S_NONE, 2'b00, 2'b00, 2'b00, 4'd0, 3'd2, 1);
    exp_cnt = 8'd0;
    rst = 1'b0;

    set_ins(7'h7F, 3'b000, 1'b0);
    fetch(3'd0, 0);
    cyc(4'd1, S_ILL, 2'b01, 2'b01, 2'b00, 4'd0, 3'd0, 2);
    cyc(4'd15, S_ILL, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 1);
    mon_en = 1'b0;

    // second instance: 4-bit counter, illegal returns to FETCH
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp2_cnt = 4'd0;
    mon2_en = 1'b1;
    repeat (17) d2_addi();
    set_ins(7'h7F, 3'b000, 1'b0);
    push2(4'd0, 1'b0, 1'b0); step(1);
    push2(4'd1, 1'b1, 1'b0); step(2);
    push2(4'd0, 1'b0, 1'b0); step(0);
    mon2_en = 1'b0;

    checks++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      errors++;
      $display("FAIL drain: leftover expected entries %0d/%0d, required 0/0", exp_q.size(), exp2_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
